icache_direct: RTL and testbench



---
 rtl/icache_direct.sv | 188 ++++++++++++++++++
 tb/tb_icache_direct.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, read-only instruction cache that sits between the
// core fetch bus (ibus) and the arbiter's CBus port. A hit answers one cycle after
// the request. A miss refills the whole line with a single INCR burst.
// Optional build macro ICACHE_PERF_EN adds the hit_cnt/miss_cnt event counters.

package icache_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [7:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    localparam logic [2:0] MSIZE8         = 3'b011;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
endpackage

// State table:
//   state     | meaning
//   IDLE      | waiting for a fetch; lookup is done combinationally on ireq
//   HIT_RESP  | one-cycle response from a valid line
//   REFILL    | line burst in flight on CBus, beats written as they arrive
//   MISS_RESP | one-cycle response taken from the line just filled
module icache_direct
    import icache_pkg::*;
#(
    parameter int NUM_LINES  = 16,
    parameter int LINE_BEATS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    output cbus_req_t  icreq,
    input  cbus_resp_t icresp,
    input  logic       flush
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int BEAT_W = $clog2(LINE_BEATS);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int OFF_W  = BEAT_W + 3;
    localparam int TAG_W  = 64 - OFF_W - IDX_W;

    typedef enum logic [1:0] {IDLE, HIT_RESP, REFILL, MISS_RESP} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [63:0]           r_addr;
    logic [NUM_LINES-1:0]  r_valid;
    logic [TAG_W-1:0]      r_tag  [NUM_LINES];
    logic [63:0]           r_data [NUM_LINES][LINE_BEATS];
    logic [BEAT_W-1:0]     r_cnt;
    logic                  r_flushed;

    logic [IDX_W-1:0]      w_req_idx;
    logic [TAG_W-1:0]      w_req_tag;
    logic                  w_hit;
    logic [IDX_W-1:0]      w_idx;
    logic [BEAT_W-1:0]     w_beat_sel;
    logic [63:0]           w_beat_word;
    logic [31:0]           w_word;
    logic                  w_accept;
    logic                  w_done;

    // A flush in the request cycle forces a miss so a stale line is never returned.
    assign w_req_idx   = ireq.addr[OFF_W +: IDX_W];
    assign w_req_tag   = ireq.addr[63 -: TAG_W];
    assign w_hit       = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag) && !flush;
    assign w_idx       = r_addr[OFF_W +: IDX_W];
    assign w_beat_sel  = r_addr[OFF_W-1:3];
    assign w_beat_word = r_data[w_idx][w_beat_sel];
    assign w_word      = r_addr[2] ? w_beat_word[63:32] : w_beat_word[31:0];
    assign w_accept    = (r_state == REFILL) && icresp.ready;
    assign w_done      = w_accept && icresp.last;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state and output decode; all outputs are zero outside the active states.
    always_comb begin
        w_next = r_state;
        iresp  = '0;
        icreq  = '0;
        case (r_state)
            IDLE: begin
                if (ireq.valid) w_next = w_hit ? HIT_RESP : REFILL;
            end
            HIT_RESP: begin
                iresp.addr_ok = 1'b1;
                iresp.data_ok = 1'b1;
                iresp.data    = w_word;
                w_next        = IDLE;
            end
            REFILL: begin
                icreq.valid = 1'b1;
                icreq.size  = MSIZE8;
                icreq.addr  = {r_addr[63:OFF_W], {OFF_W{1'b0}}};
                icreq.len   = 8'(LINE_BEATS - 1);
                icreq.burst = AXI_BURST_INCR;
                if (w_done) w_next = MISS_RESP;
            end
            MISS_RESP: begin
                iresp.addr_ok = 1'b1;
                iresp.data_ok = 1'b1;
                iresp.data    = w_word;
                w_next        = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Request address capture, beat counter and flush-during-refill tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr    <= '0;
            r_cnt     <= '0;
            r_flushed <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                r_flushed <= 1'b0;
                if (ireq.valid) r_addr <= ireq.addr;
            end else if (r_state == REFILL && flush) begin
                r_flushed <= 1'b1;
            end
            if (w_accept) r_cnt <= w_done ? '0 : r_cnt + 1'b1;
        end
    end

    // Valid bits: flush clears every line; a refill that saw a flush stays invalid.
    always_ff @(posedge clk) begin
        if (reset)                    r_valid <= '0;
        else if (flush)               r_valid <= '0;
        else if (w_done && !r_flushed) r_valid[w_idx] <= 1'b1;
    end

    // Tag and data arrays are written only by refills and carry no reset.
    always_ff @(posedge clk) begin
        if (!reset && w_accept) r_data[w_idx][r_cnt] <= icresp.data;
        if (!reset && w_done)   r_tag[w_idx] <= r_addr[63 -: TAG_W];
    end

`ifdef ICACHE_PERF_EN
    // Event counters: hits counted on HIT_RESP entry, misses on REFILL entry; flush keeps them.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (r_state == IDLE) begin
            if (w_next == HIT_RESP) hit_cnt  <= hit_cnt + 32'd1;
            if (w_next == REFILL)   miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

    // The core must hold its request stable until data_ok.
    a_req_stable: assert property (@(posedge clk) disable iff (reset)
        (r_state != IDLE) |-> (ireq.valid && ireq.addr == r_addr));

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: scenario tasks plus a randomized fetch stream,
// checked against a line-level cache model and a synthetic memory function.
module tb_icache_direct;
    import icache_pkg::*;

    localparam int NL = 16;
    localparam int LB = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    cbus_req_t  icreq;
    cbus_resp_t icresp;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    icache_direct #(.NUM_LINES(NL), .LINE_BEATS(LB)) dut (
        .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp),
        .icreq(icreq), .icresp(icresp), .flush(flush)
`ifdef ICACHE_PERF_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [31:0] seed;

    // Reference model: which line (line-aligned address) each index holds.
    bit          m_valid [NL];
    logic [63:0] m_line  [NL];
    int          m_hits, m_misses;

    function automatic logic [63:0] line_of(input logic [63:0] a);
        return a & ~64'(LB * 8 - 1);
    endfunction

    function automatic int idx_of(input logic [63:0] a);
        return int'((a / 64'(LB * 8)) % 64'(NL));
    endfunction

    function automatic logic [63:0] mem_beat(input logic [63:0] a);
        logic [31:0] lo, hi;
        lo = a[31:0];
        hi = a[63:32];
        return {lo ^ hi ^ seed ^ 32'hA5A5_0000, ~lo + seed + hi};
    endfunction

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [63:0] b;
        b = mem_beat(a & ~64'h7);
        return a[2] ? b[63:32] : b[31:0];
    endfunction

    function automatic bit model_hit(input logic [63:0] a);
        return m_valid[idx_of(a)] && (m_line[idx_of(a)] == line_of(a));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    endtask

    // Drives one fetch and plays the arbiter. flush_at: -1 none, 0 with the
    // request, k>0 during refill before beat k. reset_at: beat before which
    // reset is pulsed (-1 none). stall_max<0 means a fixed stall of -stall_max.
    task automatic do_fetch(input logic [63:0] a, input int flush_at, input int reset_at,
                            input int stall_max, output bit got, output logic [31:0] data,
                            output int lat, output int bursts, output int beats,
                            output int proto, output int l2r, output bit rst_zero);
        cbus_req_t first;
        bit in_burst = 0;
        bit fired = 0;
        int stall = 0;
        int cyc = 0;
        int last_cyc = -100;
        first = '0;
        got = 0; data = '0; lat = -1; bursts = 0; beats = 0; proto = 0; l2r = -1; rst_zero = 0;
        @(posedge clk); #1;
        ireq.valid = 1'b1;
        ireq.addr  = a;
        flush      = (flush_at == 0);
        icresp     = '0;
        while (cyc < 400) begin
            @(negedge clk);
            if (iresp.addr_ok !== iresp.data_ok) proto++;
            if (iresp.data_ok === 1'b1) begin
                got = 1; data = iresp.data; lat = cyc; l2r = cyc - last_cyc;
                break;
            end
            @(posedge clk); #1;
            cyc++;
            flush  = 1'b0;
            icresp = '0;
            if (icreq.valid === 1'b1) begin
                if (!in_burst) begin
                    in_burst = 1; bursts++; first = icreq;
                    if (icreq.addr !== line_of(a) || icreq.len !== 8'(LB - 1) ||
                        icreq.burst !== AXI_BURST_INCR || icreq.size !== MSIZE8 ||
                        icreq.is_write !== 1'b0 || icreq.strobe !== 8'h0 || icreq.data !== 64'h0)
                        proto++;
                end else if (icreq !== first) begin
                    proto++;
                end
                if (reset_at >= 0 && beats == reset_at) begin
                    reset = 1'b1;
                    @(posedge clk); #1;
                    reset = 1'b0;
                    ireq.valid = 1'b0;
                    @(negedge clk);
                    rst_zero = (iresp === '0) && (icreq === '0);
                    return;
                end
                if (flush_at > 0 && beats == flush_at && !fired) begin
                    flush = 1'b1; fired = 1;
                end
                if (stall > 0) begin
                    stall--;
                end else begin
                    icresp.ready = 1'b1;
                    icresp.data  = mem_beat(line_of(a) + 64'(beats * 8));
                    icresp.last  = (beats == LB - 1);
                    beats++;
                    if (beats == LB) begin last_cyc = cyc; in_burst = 0; end
                    stall = (stall_max < 0) ? -stall_max : int'($urandom_range(stall_max, 0));
                end
            end
        end
        @(posedge clk); #1;
        ireq.valid = 1'b0;
        icresp = '0;
        flush = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (iresp.data_ok !== 1'b0 || iresp.addr_ok !== 1'b0 || icreq.valid !== 1'b0) proto++;
        end
    endtask

    // One fetch with its transaction-level expectations, then the model update.
    task automatic fetch_step(input string nm, input logic [63:0] a, input int flush_at,
                              input int stall_max, output int bursts_o);
        bit exp_hit, got, rz;
        logic [31:0] d;
        int lat, bursts, beats, proto, l2r;
        exp_hit = model_hit(a) && (flush_at != 0);
        do_fetch(a, flush_at, -1, stall_max, got, d, lat, bursts, beats, proto, l2r, rz);
        bursts_o = bursts;
        total++;
        if (got !== 1'b1 || d !== mem_word(a)) begin
            bad++;
            $display("FAIL %s word @%h: got=%0b data=%h expected=%h", nm, a, got, d, mem_word(a));
        end
        total++;
        if (bursts !== (exp_hit ? 0 : 1) || (!exp_hit && beats !== LB)) begin
            bad++;
            $display("FAIL %s bursts @%h: bursts=%0d beats=%0d expected hit=%0b", nm, a, bursts, beats, exp_hit);
        end
        total++;
        if ((exp_hit && lat !== 1) || (!exp_hit && l2r !== 1)) begin
            bad++;
            $display("FAIL %s latency @%h: lat=%0d after_last=%0d expected 1", nm, a, lat, l2r);
        end
        total++;
        if (proto !== 0) begin
            bad++;
            $display("FAIL %s protocol @%h: violations=%0d expected 0", nm, a, proto);
        end
        if (flush_at == 0) model_clear();
        if (exp_hit) begin
            m_hits++;
        end else begin
            m_misses++;
            if (flush_at > 0) begin
                model_clear();
            end else begin
                m_valid[idx_of(a)] = 1'b1;
                m_line[idx_of(a)]  = line_of(a);
            end
        end
    endtask

    task automatic pulse_flush();
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; ireq = '0; icresp = '0;
        model_clear(); m_hits = 0; m_misses = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (iresp !== '0 || icreq !== '0) begin
            bad++;
            $display("FAIL reset_outputs: iresp=%h icreq=%h expected 0", iresp, icreq);
        end
`ifdef ICACHE_PERF_EN
        total++;
        if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            bad++;
            $display("FAIL reset_counters: hit=%0d miss=%0d expected 0", hit_cnt, miss_cnt);
        end
`endif
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_cold_miss();
        int b;
        fetch_step("cold_miss", 64'h8000_0000, -1, 0, b);
    endtask

    task automatic test_hit();
        int b;
        fetch_step("hit_same_line", 64'h8000_001C, -1, 0, b);
        total++;
        if (b !== 0) begin bad++; $display("FAIL hit_no_burst: bursts=%0d expected 0", b); end
    endtask

    task automatic test_conflict();
        int b, sum;
        logic [63:0] seq [3];
        seq[0] = 64'h8000_0000; seq[1] = 64'h8000_0400; seq[2] = 64'h8000_0000;
        pulse_flush();
        sum = 0;
        for (int i = 0; i < 3; i++) begin
            fetch_step("conflict", seq[i] + 64'(4 * i), -1, 1, b);
            sum += b;
        end
        total++;
        if (sum !== 3) begin bad++; $display("FAIL conflict_bursts: bursts=%0d expected 3", sum); end
        // Same low 32 bits, different upper tag bits: must not alias.
        fetch_step("high_tag", 64'h1_8000_0008, -1, 0, b);
        total++;
        if (b !== 1) begin bad++; $display("FAIL high_tag_miss: bursts=%0d expected 1", b); end
    endtask

    task automatic test_flush();
        int b;
        fetch_step("flush_fill", 64'h8000_0000, -1, 0, b);
        pulse_flush();
        fetch_step("flush_refetch", 64'h8000_0004, -1, 0, b);
        total++;
        if (b !== 1) begin bad++; $display("FAIL flush_refetch_burst: bursts=%0d expected 1", b); end
        fetch_step("flush_mid_refill", 64'h8000_0048, 3, 1, b);
        fetch_step("after_mid_flush", 64'h8000_0048, -1, 0, b);
        total++;
        if (b !== 1) begin bad++; $display("FAIL mid_flush_refetch: bursts=%0d expected 1", b); end
        fetch_step("flush_with_req", 64'h8000_0048, 0, 0, b);
        total++;
        if (b !== 1) begin bad++; $display("FAIL flush_with_req: bursts=%0d expected 1", b); end
    endtask

    task automatic test_stall();
        int b;
        fetch_step("stall_fill", 64'h8000_0134, -1, -5, b);
        fetch_step("stall_hit", 64'h8000_0100, -1, 0, b);
        total++;
        if (b !== 0) begin bad++; $display("FAIL stall_line_hit: bursts=%0d expected 0", b); end
    endtask

    task automatic test_reset_mid_refill();
        bit got, rz;
        logic [31:0] d;
        int lat, bursts, beats, proto, l2r, b;
        do_fetch(64'h8000_0200, -1, 3, 0, got, d, lat, bursts, beats, proto, l2r, rz);
        model_clear(); m_hits = 0; m_misses = 0;
        total++;
        if (rz !== 1'b1 || got !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_refill: outputs_zero=%0b resp=%0b expected 1/0", rz, got);
        end
        fetch_step("after_reset", 64'h8000_0208, -1, 0, b);
        total++;
        if (b !== 1) begin bad++; $display("FAIL after_reset_burst: bursts=%0d expected 1", b); end
`ifdef ICACHE_PERF_EN
        total++;
        if (hit_cnt !== 32'd0 || miss_cnt !== 32'd1) begin
            bad++;
            $display("FAIL reset_perf: hit=%0d miss=%0d expected 0/1", hit_cnt, miss_cnt);
        end
`endif
    endtask

    task automatic test_random();
        int b, fa;
        logic [63:0] bases [3];
        logic [63:0] a;
        bases[0] = 64'h8000_0000; bases[1] = 64'h8000_0400; bases[2] = 64'h1_8000_0000;
        for (int n = 0; n < 60; n++) begin
            a = bases[$urandom_range(2, 0)] + 64'($urandom_range(3, 0) * LB * 8)
                + 64'($urandom_range(2 * LB - 1, 0) * 4);
            case ($urandom_range(9, 0))
                0:       fa = 0;
                1:       fa = int'($urandom_range(LB - 1, 1));
                default: fa = -1;
            endcase
            fetch_step("random", a, fa, int'($urandom_range(3, 0)), b);
        end
`ifdef ICACHE_PERF_EN
        total++;
        if (hit_cnt !== 32'(m_hits) || miss_cnt !== 32'(m_misses)) begin
            bad++;
            $display("FAIL perf_counts: hit=%0d miss=%0d expected %0d/%0d", hit_cnt, miss_cnt, m_hits, m_misses);
        end
`endif
    endtask

    initial begin
        seed = $urandom;
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush();
        test_stall();
        test_reset_mid_refill();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
